// File: rtl/cpu_boot_ctrl.sv
// Boot/run controller: streams images into NUM_CH cpu memories, optionally zero-fills
// the remainder of each memory, then enables the cpu until a STOP opcode or a timeout.
module cpu_boot_ctrl #(
    parameter int         NUM_CH    = 2,
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 32,
    parameter int         DEPTH     = 1024,
    parameter int         LEN_W     = 11,
    parameter int         ZERO_FILL = 1,
    parameter logic [5:0] STOP_OPC  = 6'b111110,
    parameter int         CNT_W     = 32,
    parameter int         MAX_CYC   = 2**20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    output logic [NUM_CH*ADDR_W-1:0] ext_addr,
    output logic [NUM_CH-1:0]        ext_wen,
    output logic [NUM_CH-1:0]        ext_ren,
    output logic [NUM_CH*DATA_W-1:0] ext_wdata,
    output logic                     cpu_enable,
    input  logic [31:0]              instr,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [1:0]               stop_code,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout
);

    localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q [NUM_CH];
    logic [LEN_W-1:0]   len_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic [1:0]         stop_code_q, stop_code_d;
    logic [NUM_CH-1:0]  wen_q, wen_d;
    logic [ADDR_W-1:0]  addr_q [NUM_CH];
    logic [ADDR_W-1:0]  addr_d [NUM_CH];
    logic [DATA_W-1:0]  wdata_q [NUM_CH];
    logic [DATA_W-1:0]  wdata_d [NUM_CH];
    logic [LEN_W-1:0]   cur_len;
    logic               unused_instr_bits;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > DEPTH_L) ? DEPTH_L : l;
    endfunction

    assign cur_len           = len_q[ch_q];
    assign unused_instr_bits = ^instr[25:2];

    assign s_ready    = (state_q == S_LOAD) && (idx_q < cur_len);
    assign cpu_enable = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign timeout    = timeout_q;
    assign stop_code  = stop_code_q;
    assign cycle_cnt  = cnt_q;
    assign ext_wen    = wen_q;
    assign ext_ren    = '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign ext_addr[g*ADDR_W +: ADDR_W]  = addr_q[g];
        assign ext_wdata[g*DATA_W +: DATA_W] = wdata_q[g];
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        idx_d       = idx_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        stop_code_d = stop_code_q;
        wen_d       = '0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        len_d[i] = clamp_len(ch_len[i*LEN_W +: LEN_W]);
                    end
                    cnt_d       = '0;
                    timeout_d   = 1'b0;
                    stop_code_d = 2'b00;
                    ch_d        = '0;
                    idx_d       = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (idx_q == cur_len) begin
                    state_d = S_FILL;
                end else if (s_valid) begin
                    wen_d[ch_q]   = 1'b1;
                    addr_d[ch_q]  = ADDR_W'({idx_q, 2'b00});
                    wdata_d[ch_q] = s_data;
                    idx_d         = idx_q + LEN_W'(1);
                end
            end
            S_FILL: begin
                if ((ZERO_FILL != 0) && (idx_q < DEPTH_L)) begin
                    wen_d[ch_q]   = 1'b1;
                    addr_d[ch_q]  = ADDR_W'({idx_q, 2'b00});
                    wdata_d[ch_q] = '0;
                    idx_d         = idx_q + LEN_W'(1);
                end else if (ch_q == LAST_CH) begin
                    state_d = S_SETTLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            // One quiet cycle so the last memory write lands before the cpu starts.
            S_SETTLE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (instr[31:26] == STOP_OPC) begin
                    stop_code_d = instr[1:0];
                    state_d     = S_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            stop_code_q <= 2'b00;
            wen_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                len_q[i]   <= '0;
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            stop_code_q <= stop_code_d;
            wen_q       <= wen_d;
            for (int i = 0; i < NUM_CH; i++) begin
                len_q[i]   <= len_d[i];
                addr_q[i]  <= addr_d[i];
                wdata_q[i] <= wdata_d[i];
            end
        end
    end

endmodule
